// File: rtl/simd_pmul_seq.sv
// rtl/simd_pmul_seq.sv - iterative SIMD unsigned multiplier via 2x2 partial-product reduction
module simd_pmul_seq #(
  parameter int VECTOR_WIDTH = 64,
  localparam int LMAX = $clog2(VECTOR_WIDTH),
  localparam int MODE_W = ($clog2(LMAX - 2) < 1) ? 1 : $clog2(LMAX - 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VECTOR_WIDTH-1:0]   a,
  input  logic [VECTOR_WIDTH-1:0]   b,
  input  logic [MODE_W-1:0]         mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*VECTOR_WIDTH-1:0] out_data
);

  localparam int V = VECTOR_WIDTH;
  // Every level of the matrix fits in V*V bits: level 0 and level 1 fill it
  // exactly, deeper levels use a shrinking prefix.
  localparam int MW = V * V;
  localparam int CNT_W = $clog2(LMAX + 1);
  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(LMAX - 3);

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [MW-1:0]       m_q, m_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic [2*V-1:0]      out_data_q, out_data_d;

  logic [MW-1:0]       m0;
  logic [MW-1:0]       red_all [LMAX];
  logic [2*V-1:0]      diag_all [LMAX-2];
  logic [2*V-1:0]      diag_sel;
  logic [MODE_W-1:0]   mode_clamped;
  logic [CNT_W-1:0]    last_cnt;

  // Level-0 bit product matrix, entry (i,j) at bit i*V+j.
  for (genvar i = 0; i < V; i++) begin : g_m0_row
    for (genvar j = 0; j < V; j++) begin : g_m0_col
      assign m0[i*V+j] = a[i] & b[j];
    end
  end

  // One reduction stage per level k -> k+1. Entry (i,j) of a level with
  // dimension D and entry width W lives at offset (i*D+j)*W.
  for (genvar k = 0; k < LMAX; k++) begin : g_lvl
    localparam int DI = V >> k;
    localparam int DO = DI / 2;
    localparam int WI = (k == 0) ? 1 : (2 << k);
    localparam int WO = 4 << k;
    localparam int CW = 1 << k;
    logic [MW-1:0] red;
    for (genvar i = 0; i < DO; i++) begin : g_row
      for (genvar j = 0; j < DO; j++) begin : g_col
        logic [WO-1:0] m00, m01, m10, m11;
        assign m00 = {{(WO-WI){1'b0}}, m_q[((2*i)*DI + 2*j)*WI +: WI]};
        assign m01 = {{(WO-WI){1'b0}}, m_q[((2*i)*DI + 2*j+1)*WI +: WI]};
        assign m10 = {{(WO-WI){1'b0}}, m_q[((2*i+1)*DI + 2*j)*WI +: WI]};
        assign m11 = {{(WO-WI){1'b0}}, m_q[((2*i+1)*DI + 2*j+1)*WI +: WI]};
        assign red[(i*DO + j)*WO +: WO] = (m11 << (2*CW)) + ((m10 + m01) << CW) + m00;
      end
    end
    if (DO*DO*WO < MW) begin : g_pad
      assign red[MW-1:DO*DO*WO] = '0;
    end
    assign red_all[k] = red;
  end

  // Diagonal read-out of level L (lane width 2^L) for each selectable L.
  for (genvar l = 3; l <= LMAX; l++) begin : g_diag
    localparam int D = V >> l;
    localparam int WE = 2 << l;
    for (genvar n = 0; n < D; n++) begin : g_lane
      assign diag_all[l-3][n*WE +: WE] = red_all[l-1][(n*D + n)*WE +: WE];
    end
  end

  assign mode_clamped = (int'(mode) > LMAX - 3) ? MODE_MAX : mode;
  assign last_cnt     = CNT_W'(mode_q) + CNT_W'(2);

  // Pick the diagonal matching the latched lane width.
  always_comb begin
    diag_sel = '0;
    for (int k = 0; k < LMAX - 2; k++) begin
      if (mode_q == MODE_W'(k)) diag_sel = diag_all[k];
    end
  end

  // Next-state logic: accept, reduce one level per cycle, hold result until taken.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          m_d     = m0;
          mode_d  = mode_clamped;
          cnt_d   = '0;
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        for (int k = 0; k < LMAX; k++) begin
          if (cnt_q == CNT_W'(k)) m_d = red_all[k];
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == last_cnt) begin
          out_data_d = diag_sel;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;

endmodule
